ball_game_ctrl: RTL and testbench

- Game sequencer for the bouncing-ball datapath. Runs one frame-rate FSM: idle, serve countdown, play, miss handling and game over.
- Drives the ball block's active-low reset and its 4-bit crash vector {left,right,up,down}, gated by game state.
- Keeps score (paddle hits) and lives; exposes state for the display/HUD logic.

---
 rtl/ball_game_ctrl_pkg.sv | 39 +++
 rtl/ball_game_ctrl_collide.sv | 43 ++++
 rtl/ball_game_ctrl.sv | 138 +++++++++++++
 tb/tb_ball_game_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_game_ctrl_pkg.sv
// Shared definitions for the bouncing-ball game: state codes, screen geometry,
// the crash-vector payload and the ball block's orientation codes.
package ball_game_ctrl_pkg;

    localparam int unsigned SCREEN_W     = 640;
    localparam int unsigned SCREEN_H     = 480;
    localparam int unsigned BALL_SIZE    = 8;
    localparam int unsigned PADDLE_W     = 64;
    localparam int unsigned PADDLE_Y     = 440;
    localparam int unsigned HIT_WIN      = 4;
    localparam int unsigned SERVE_FRAMES = 60;
    localparam int unsigned INIT_LIVES   = 3;
    localparam int unsigned SCORE_W      = 8;
    localparam int unsigned POS_W        = 10;
    localparam int unsigned CMP_W        = 11;
    localparam int unsigned LIVES_W      = 3;

    // Direction codes shared with the ball block
    localparam logic [1:0] BALL_TOWARD_UP_LEFT    = 2'd0;
    localparam logic [1:0] BALL_TOWARD_UP_RIGHT   = 2'd1;
    localparam logic [1:0] BALL_TOWARD_DOWN_LEFT  = 2'd2;
    localparam logic [1:0] BALL_TOWARD_DOWN_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
    } crash_t;

endpackage

// File: rtl/ball_game_ctrl_collide.sv
// ball_collide: combinational wall/paddle/miss detection from ball and paddle
// positions, widened to 11 bits so the far-edge sums cannot wrap.
module ball_collide #(
    parameter int unsigned SCREEN_W  = ball_game_ctrl_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H  = ball_game_ctrl_pkg::SCREEN_H,
    parameter int unsigned BALL_SIZE = ball_game_ctrl_pkg::BALL_SIZE,
    parameter int unsigned PADDLE_W  = ball_game_ctrl_pkg::PADDLE_W,
    parameter int unsigned PADDLE_Y  = ball_game_ctrl_pkg::PADDLE_Y,
    parameter int unsigned HIT_WIN   = ball_game_ctrl_pkg::HIT_WIN
) (
    input  logic [ball_game_ctrl_pkg::POS_W-1:0] i_ball_x,
    input  logic [ball_game_ctrl_pkg::POS_W-1:0] i_ball_y,
    input  logic [ball_game_ctrl_pkg::POS_W-1:0] i_paddle_x,
    output ball_game_ctrl_pkg::crash_t           o_crash_c,
    output logic                                 o_miss_c
);
    import ball_game_ctrl_pkg::*;

    logic [CMP_W-1:0] w_x;
    logic [CMP_W-1:0] w_y;
    logic [CMP_W-1:0] w_px;
    logic [CMP_W-1:0] w_x_end;
    logic [CMP_W-1:0] w_y_end;
    logic [CMP_W-1:0] w_px_end;

    assign w_x      = CMP_W'(i_ball_x);
    assign w_y      = CMP_W'(i_ball_y);
    assign w_px     = CMP_W'(i_paddle_x);
    assign w_x_end  = w_x + CMP_W'(BALL_SIZE);
    assign w_y_end  = w_y + CMP_W'(BALL_SIZE);
    assign w_px_end = w_px + CMP_W'(PADDLE_W);

    assign o_crash_c.left  = (w_x <= CMP_W'(2));
    assign o_crash_c.right = (w_x_end >= CMP_W'(SCREEN_W - 2));
    assign o_crash_c.up    = (w_y <= CMP_W'(2));
    // Paddle hit: bottom edge inside the hit window and horizontal overlap
    assign o_crash_c.down  = (w_y_end >= CMP_W'(PADDLE_Y))
                          && (w_y_end <= CMP_W'(PADDLE_Y + HIT_WIN))
                          && (w_x_end > w_px)
                          && (w_x < w_px_end);
    assign o_miss_c        = (w_y_end >= CMP_W'(SCREEN_H));

endmodule

// File: rtl/ball_game_ctrl.sv
// ball_game_ctrl: frame-rate game sequencer (idle/serve/play/miss/over) that
// gates the ball block's reset and crash inputs and tracks score and lives.
module ball_game_ctrl #(
    parameter int unsigned SCREEN_W     = ball_game_ctrl_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H     = ball_game_ctrl_pkg::SCREEN_H,
    parameter int unsigned BALL_SIZE    = ball_game_ctrl_pkg::BALL_SIZE,
    parameter int unsigned PADDLE_W     = ball_game_ctrl_pkg::PADDLE_W,
    parameter int unsigned PADDLE_Y     = ball_game_ctrl_pkg::PADDLE_Y,
    parameter int unsigned HIT_WIN      = ball_game_ctrl_pkg::HIT_WIN,
    parameter int unsigned SERVE_FRAMES = ball_game_ctrl_pkg::SERVE_FRAMES,
    parameter int unsigned INIT_LIVES   = ball_game_ctrl_pkg::INIT_LIVES,
    parameter int unsigned SCORE_W      = ball_game_ctrl_pkg::SCORE_W
) (
    input  logic                                 iFrame_CLK,
    input  logic                                 iRST_n,
    input  logic                                 iStart,
    input  logic [ball_game_ctrl_pkg::POS_W-1:0] iBall_x,
    input  logic [ball_game_ctrl_pkg::POS_W-1:0] iBall_y,
    input  logic [ball_game_ctrl_pkg::POS_W-1:0] iPaddle_x,
    output logic [3:0]                           oCrash,
    output logic                                 oBall_RST_n,
    output logic [SCORE_W-1:0]                   oScore,
    output logic [2:0]                           oLives,
    output logic [2:0]                           oState
);
    import ball_game_ctrl_pkg::*;

    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    game_state_e        r_state,       w_state_nxt;
    logic [CNT_W-1:0]   r_serve_cnt,   w_serve_cnt_nxt;
    logic [SCORE_W-1:0] r_score,       w_score_nxt;
    logic [LIVES_W-1:0] r_lives,       w_lives_nxt;
    logic               r_hit_q,       w_hit_q_nxt;
    logic               r_ball_rst_n,  w_ball_rst_n_nxt;
    crash_t             w_crash;
    logic               w_miss;

    ball_collide #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_W  (PADDLE_W),
        .PADDLE_Y  (PADDLE_Y),
        .HIT_WIN   (HIT_WIN)
    ) u_collide (
        .i_ball_x   (iBall_x),
        .i_ball_y   (iBall_y),
        .i_paddle_x (iPaddle_x),
        .o_crash_c  (w_crash),
        .o_miss_c   (w_miss)
    );

    always_ff @(posedge iFrame_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state      <= ST_IDLE;
            r_serve_cnt  <= '0;
            r_score      <= '0;
            r_lives      <= LIVES_W'(INIT_LIVES);
            r_hit_q      <= 1'b0;
            r_ball_rst_n <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_serve_cnt  <= w_serve_cnt_nxt;
            r_score      <= w_score_nxt;
            r_lives      <= w_lives_nxt;
            r_hit_q      <= w_hit_q_nxt;
            r_ball_rst_n <= w_ball_rst_n_nxt;
        end
    end

    // Ball reset is released exactly while the next state is PLAY
    always_comb begin
        w_state_nxt      = r_state;
        w_serve_cnt_nxt  = r_serve_cnt;
        w_score_nxt      = r_score;
        w_lives_nxt      = r_lives;
        w_hit_q_nxt      = 1'b0;
        w_ball_rst_n_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_score_nxt = '0;
                w_lives_nxt = LIVES_W'(INIT_LIVES);
                if (iStart) begin
                    w_state_nxt     = ST_SERVE;
                    w_serve_cnt_nxt = '0;
                end
            end
            ST_SERVE: begin
                if (r_serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                    w_state_nxt      = ST_PLAY;
                    w_serve_cnt_nxt  = '0;
                    w_ball_rst_n_nxt = 1'b1;
                end else begin
                    w_serve_cnt_nxt = r_serve_cnt + CNT_W'(1);
                end
            end
            ST_PLAY: begin
                if (w_miss) begin
                    w_state_nxt = ST_MISS;
                    w_lives_nxt = r_lives - LIVES_W'(1);
                end else begin
                    w_ball_rst_n_nxt = 1'b1;
                    w_hit_q_nxt      = w_crash.down;
                    if (w_crash.down && !r_hit_q && (r_score != '1)) begin
                        w_score_nxt = r_score + SCORE_W'(1);
                    end
                end
            end
            ST_MISS: begin
                if (r_lives == '0) begin
                    w_state_nxt = ST_OVER;
                end else begin
                    w_state_nxt     = ST_SERVE;
                    w_serve_cnt_nxt = '0;
                end
            end
            ST_OVER: begin
                if (iStart) begin
                    w_state_nxt     = ST_SERVE;
                    w_serve_cnt_nxt = '0;
                    w_score_nxt     = '0;
                    w_lives_nxt     = LIVES_W'(INIT_LIVES);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign oCrash      = (r_state == ST_PLAY) ? 4'(w_crash) : 4'b0000;
    assign oBall_RST_n = r_ball_rst_n;
    assign oScore      = r_score;
    assign oLives      = r_lives;
    assign oState      = 3'(r_state);

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Bench for ball_game_ctrl: a frame-level game model checked every frame,
// plus directed scenarios with literal expectations.
module tb_ball_game_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] bx = 10'd300, by = 10'd200, px = 10'd0;
    logic [3:0] crash;
    logic       brst;
    logic [7:0] score;
    logic [2:0] lives, state;

    // Second instance whose screen height makes a paddle hit and a miss coincide
    logic       start2 = 1'b0;
    logic [9:0] bx2 = 10'd120, by2 = 10'd200, px2 = 10'd100;
    logic [3:0] crash2;
    logic       brst2;
    logic [7:0] score2;
    logic [2:0] lives2, state2;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    ball_game_ctrl u_dut (
        .iFrame_CLK (clk), .iRST_n (rst_n), .iStart (start),
        .iBall_x (bx), .iBall_y (by), .iPaddle_x (px),
        .oCrash (crash), .oBall_RST_n (brst), .oScore (score),
        .oLives (lives), .oState (state)
    );

    ball_game_ctrl #(.SCREEN_H(444)) u_dut2 (
        .iFrame_CLK (clk), .iRST_n (rst_n), .iStart (start2),
        .iBall_x (bx2), .iBall_y (by2), .iPaddle_x (px2),
        .oCrash (crash2), .oBall_RST_n (brst2), .oScore (score2),
        .oLives (lives2), .oState (state2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game rules at frame granularity: 0 idle, 1 serve, 2 play, 3 miss, 4 over
    int m_state = 0, m_left = 0, m_score = 0, m_lives = 3;
    bit m_prev = 1'b0;

    function automatic bit hit_now(input int x, input int y, input int p);
        return (y + 8 >= 440) && (y + 8 <= 444) && (x + 8 > p) && (x < p + 64);
    endfunction

    function automatic logic [3:0] exp_crash(input int st, input int x, input int y, input int p);
        if (st != 2) return 4'b0000;
        return {x <= 2, x + 8 >= 638, y <= 2, hit_now(x, y, p)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit h, was_play;
        if (!rst_n) begin
            m_state = 0; m_left = 0; m_score = 0; m_lives = 3; m_prev = 1'b0;
        end else begin
            h        = hit_now(int'(bx), int'(by), int'(px));
            was_play = (m_state == 2);
            case (m_state)
                0: begin
                    m_score = 0; m_lives = 3;
                    if (start) begin m_state = 1; m_left = 60; end
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_state = 2;
                end
                2: begin
                    if (int'(by) + 8 >= 480) begin
                        m_lives = m_lives - 1; m_state = 3;
                    end else if (h && !m_prev && m_score < 255) begin
                        m_score = m_score + 1;
                    end
                end
                3: begin
                    if (m_lives == 0) m_state = 4;
                    else begin m_state = 1; m_left = 60; end
                end
                default: begin
                    if (start) begin m_state = 1; m_left = 60; m_score = 0; m_lives = 3; end
                end
            endcase
            m_prev = (was_play && m_state == 2) ? h : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_state", int'(state), m_state);
            chk("m_ball_rst_n", int'(brst), int'(m_state == 2));
            chk("m_score", int'(score), m_score);
            chk("m_lives", int'(lives), m_lives);
            chk("m_crash", int'(crash), int'(exp_crash(m_state, int'(bx), int'(by), int'(px))));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_play(input string name);
        int n = 0;
        while (state != 3'd2 && n < 100) begin
            tick();
            n++;
        end
        chk(name, int'(state), 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #2;
        cmp_en = 1'b1;
        tick();
        bx = 10'd0;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_score", int'(score), 0);
        chk("rst_ball_rst_n", int'(brst), 0);
        chk("rst_crash", int'(crash), 0);
        bx = 10'd300;
        rst_n = 1'b1;
        tick();

        // Serve hold: 60 frames in SERVE, PLAY on the 61st edge
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("serve_enter", int'(state), 1);
        bx = 10'd0;
        #1 chk("serve_crash_gated", int'(crash), 0);
        bx = 10'd300;
        repeat (59) tick();
        chk("serve_last_state", int'(state), 1);
        chk("serve_last_brst", int'(brst), 0);
        tick();
        chk("play_state", int'(state), 2);
        chk("play_brst", int'(brst), 1);

        bx = 10'd0;
        #1 chk("crash_left", int'(crash), 4'b1000);
        tick();
        bx = 10'd632;
        #1 chk("crash_right", int'(crash), 4'b0100);
        tick();
        bx = 10'd300; by = 10'd2;
        #1 chk("crash_up", int'(crash), 4'b0010);
        tick();
        by = 10'd200;

        // Held paddle contact counts once
        px = 10'd100; bx = 10'd120; by = 10'd432;
        repeat (3) begin
            #1 chk("crash_down", int'(crash), 4'b0001);
            tick();
        end
        by = 10'd200;
        chk("hit_once", int'(score), 1);

        bx = 10'd300; by = 10'd472;
        tick();
        chk("miss_state", int'(state), 3);
        chk("miss_lives", int'(lives), 2);
        by = 10'd200;
        tick();
        chk("miss_to_serve", int'(state), 1);
        chk("miss_brst", int'(brst), 0);
        wait_play("serve2_timeout");
        by = 10'd472; tick(); by = 10'd200; tick();
        chk("lives_1", int'(lives), 1);
        wait_play("serve3_timeout");
        by = 10'd472; tick(); by = 10'd200;
        chk("lives_0", int'(lives), 0);
        tick();
        chk("over_state", int'(state), 4);
        start = 1'b0;
        repeat (3) tick();
        chk("over_hold", int'(state), 4);
        chk("over_score_frozen", int'(score), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_state", int'(state), 1);
        chk("restart_score", int'(score), 0);
        chk("restart_lives", int'(lives), 3);

        // Saturation: 256 separate hits leave the score at 255
        wait_play("serve4_timeout");
        px = 10'd100; bx = 10'd120;
        repeat (256) begin
            by = 10'd432; tick();
            by = 10'd200; tick();
        end
        chk("score_saturate", int'(score), 255);

        // Asynchronous reset mid-play, checked before any clock edge
        bx = 10'd0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_brst", int'(brst), 0);
        chk("async_crash", int'(crash), 0);
        tick();
        bx = 10'd300;
        rst_n = 1'b1;
        tick();

        // Hit and miss together: miss wins, no score
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (60) tick();
        chk("dut2_play", int'(state2), 2);
        by2 = 10'd436;
        #1 chk("dut2_crash_down", int'(crash2), 4'b0001);
        tick();
        chk("dut2_miss_state", int'(state2), 3);
        chk("dut2_miss_score", int'(score2), 0);
        chk("dut2_miss_lives", int'(lives2), 2);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
